// File: rtl/fx_issue_scheduler.sv
// In-order FX issue queue with RAW hazard interlock and multiply occupancy.
// Issues at most one instruction per cycle into a two-stage FX pipeline.
module fx_issue_scheduler #(
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int MUL_OPCODE = 7
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [5:0]               in_opCode_i,
  input  logic [4:0]               in_destAddress_i,
  input  logic [4:0]               in_srcAddress_i,
  input  logic                     fx_ready_i,
  output logic                     issue_valid_o,
  output logic [5:0]               issue_opCode_o,
  output logic [4:0]               issue_destAddress_o,
  output logic [4:0]               issue_srcAddress_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     mulBusy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [3:0]    MUL_LD  = 4'(MUL_CYCLES - 1);
  localparam logic [5:0]    MUL_OP  = 6'(MUL_OPCODE);

  logic [5:0]    op_q   [DEPTH];
  logic [4:0]    dst_q  [DEPTH];
  logic [4:0]    src_q  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          s2_valid;
  logic [4:0]    s2_dest;
  logic [3:0]    mul_cnt;
  logic [4:0]    head_src;
  logic          hazard;
  logic          push;
  logic          pop;

  assign head_src   = src_q[rd_ptr];
  assign mulBusy_o  = (mul_cnt != 4'd0);
  assign in_ready_o = (count_o < FULL);

  // Head operand collides with a result still in the FX pipe (no bypass).
  always_comb begin
    hazard = 1'b0;
    if (issue_valid_o && (head_src == issue_destAddress_o))
      hazard = 1'b1;
    if (s2_valid && (head_src == s2_dest))
      hazard = 1'b1;
  end

  // Accept and issue qualifiers; flush suppresses both.
  always_comb begin
    push = in_valid_i && in_ready_o && !flush_i;
    pop  = (count_o != '0) && fx_ready_i && !mulBusy_o
           && !hazard && !flush_i;
  end

  // Payload storage; contents of empty slots are never observed.
  always_ff @(posedge clock_i) begin
    if (push) begin
      op_q[wr_ptr]  <= in_opCode_i;
      dst_q[wr_ptr] <= in_destAddress_i;
      src_q[wr_ptr] <= in_srcAddress_i;
    end
  end

  // Circular pointers and occupancy; power-of-two depth wraps naturally.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // Issue register: one-cycle valid pulse, fields hold between issues.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      issue_valid_o       <= 1'b0;
      issue_opCode_o      <= '0;
      issue_destAddress_o <= '0;
      issue_srcAddress_o  <= '0;
    end else if (flush_i) begin
      issue_valid_o <= 1'b0;
    end else begin
      issue_valid_o <= pop;
      if (pop) begin
        issue_opCode_o      <= op_q[rd_ptr];
        issue_destAddress_o <= dst_q[rd_ptr];
        issue_srcAddress_o  <= src_q[rd_ptr];
      end
    end
  end

  // Second FX stage tracker for the hazard check.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      s2_valid <= 1'b0;
      s2_dest  <= '0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= issue_valid_o;
      s2_dest  <= issue_destAddress_o;
    end
  end

  // Multiply occupancy countdown, loaded when a multiply issues.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i)
      mul_cnt <= '0;
    else if (pop && (op_q[rd_ptr] == MUL_OP))
      mul_cnt <= MUL_LD;
    else if (mul_cnt != 4'd0)
      mul_cnt <= mul_cnt - 4'd1;
  end

endmodule

// File: tb/tb_fx_issue_scheduler.sv
// Bench for fx_issue_scheduler: queue/time model plus directed scenarios.
// Model tracks issue times per instruction rather than pipeline registers.
module tb_fx_issue_scheduler;

  localparam int DEPTH = 4;
  localparam int MULC  = 4;
  localparam int MULOP = 7;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, fx_ready;
  logic [5:0] in_op;
  logic [4:0] in_dst, in_src;
  logic       in_ready, iv, mul_busy;
  logic [5:0] i_op;
  logic [4:0] i_dst, i_src;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  fx_issue_scheduler #(
    .DEPTH(DEPTH), .MUL_CYCLES(MULC), .MUL_OPCODE(MULOP)
  ) dut (
    .clock_i(clk), .reset_i(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_opCode_i(in_op), .in_destAddress_i(in_dst),
    .in_srcAddress_i(in_src), .fx_ready_i(fx_ready),
    .issue_valid_o(iv), .issue_opCode_o(i_op),
    .issue_destAddress_o(i_dst), .issue_srcAddress_o(i_src),
    .count_o(count), .mulBusy_o(mul_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [4:0] dst;
    logic [4:0] src;
  } ent_t;

  ent_t       mq[$];
  int         ht[$];
  logic [4:0] hd[$];
  int         cyc = 0;
  int         mul_t = -100;
  bit         started = 0;
  bit         e_iv = 0;
  ent_t       e_f = '{6'd0, 5'd0, 5'd0};

  // Cycle c is busy if a multiply was chosen at t with t < c < t+MULC.
  function automatic bit m_busy(input int c);
    return (c > mul_t) && (c < mul_t + MULC);
  endfunction

  always @(posedge clk) begin
    bit   haz, do_pop, do_push;
    ent_t h;
    if (reset) begin
      started = 1;
      mq.delete(); ht.delete(); hd.delete();
      mul_t = -100;
      e_iv = 0;
      e_f = '{6'd0, 5'd0, 5'd0};
    end else if (flush) begin
      mq.delete(); ht.delete(); hd.delete();
      mul_t = -100;
      e_iv = 0;
    end else begin
      haz = 0;
      if (mq.size() > 0)
        for (int k = 0; k < ht.size(); k++)
          if ((cyc - ht[k] == 1 || cyc - ht[k] == 2)
              && hd[k] == mq[0].src)
            haz = 1;
      do_pop  = mq.size() > 0 && fx_ready && !m_busy(cyc) && !haz;
      do_push = in_valid && mq.size() < DEPTH;
      e_iv = do_pop;
      if (do_pop) begin
        h = mq.pop_front();
        e_f = h;
        ht.push_back(cyc);
        hd.push_back(h.dst);
        if (ht.size() > 4) begin
          void'(ht.pop_front());
          void'(hd.pop_front());
        end
        if (h.op == 6'(MULOP)) mul_t = cyc;
      end
      if (do_push) mq.push_back('{in_op, in_dst, in_src});
    end
    cyc++;
  end

  // Every cycle after reset: compare all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("count", int'(count), mq.size());
      chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      chk("mulBusy", int'(mul_busy), int'(m_busy(cyc)));
      chk("issue_valid", int'(iv), int'(e_iv));
      chk("issue_op", int'(i_op), int'(e_f.op));
      chk("issue_dst", int'(i_dst), int'(e_f.dst));
      chk("issue_src", int'(i_src), int'(e_f.src));
    end
  end

  task automatic go(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input int op, input int d, input int s);
    in_valid = 1'b1;
    in_op    = 6'(op);
    in_dst   = 5'(d);
    in_src   = 5'(s);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; fx_ready = 0;
    in_op = 0; in_dst = 0; in_src = 0;
    go(2);
    reset = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_iv", int'(iv), 0);
    chk("rst_dst", int'(i_dst), 0);

    // Fill: 5 offered, 4 accepted, then drain in order.
    for (int k = 0; k < 5; k++) begin
      offer(14, 10 + k, 20 + k);
      go();
      if (k == 3) chk("full_ready", int'(in_ready), 0);
    end
    in_valid = 0;
    chk("full_count", int'(count), 4);
    fx_ready = 1;
    go();
    chk("drain0_iv", int'(iv), 1);
    chk("drain0_dst", int'(i_dst), 10);
    go();
    chk("drain1_dst", int'(i_dst), 11);
    go(6);
    chk("drain_empty", int'(count), 0);

    // RAW hazard: B reads r3 written by A.
    fx_ready = 0;
    offer(14, 3, 1); go();
    offer(14, 5, 3); go();
    in_valid = 0;
    fx_ready = 1;
    go();
    chk("haz_a_iv", int'(iv), 1);
    chk("haz_a_dst", int'(i_dst), 3);
    go();
    chk("haz_b1", int'(iv), 0);
    go();
    chk("haz_b2", int'(iv), 0);
    go();
    chk("haz_b_iv", int'(iv), 1);
    chk("haz_b_dst", int'(i_dst), 5);
    go(4);

    // Multiply blocks the unit for MUL_CYCLES cycles.
    fx_ready = 0;
    offer(MULOP, 8, 9); go();
    offer(14, 11, 12); go();
    in_valid = 0;
    fx_ready = 1;
    go();
    chk("mul_iv", int'(iv), 1);
    chk("mul_busy1", int'(mul_busy), 1);
    go();
    chk("mul_busy2", int'(mul_busy), 1);
    chk("mul_iv2", int'(iv), 0);
    go();
    chk("mul_busy3", int'(mul_busy), 1);
    go();
    chk("mul_busy4", int'(mul_busy), 0);
    chk("mul_iv4", int'(iv), 0);
    go();
    chk("mul_next_iv", int'(iv), 1);
    chk("mul_next_dst", int'(i_dst), 11);
    go(4);

    // Streaming with pointer wrap.
    fx_ready = 0;
    for (int k = 0; k < 4; k++) begin
      offer(14, 16 + k, k); go();
    end
    in_valid = 0;
    chk("wrap_full", int'(count), 4);
    fx_ready = 1;
    for (int k = 0; k < 8; k++) begin
      offer(14, 20 + k, 4 + (k % 4));
      go();
      chk("wrap_count", int'(count), 3);
    end
    in_valid = 0;
    go(10);
    chk("wrap_drained", int'(count), 0);

    // Flush with queued entries and a multiply in flight.
    fx_ready = 0;
    offer(MULOP, 1, 2); go();
    offer(14, 4, 5); go();
    offer(14, 6, 7); go();
    offer(14, 9, 10); go();
    in_valid = 0;
    fx_ready = 1;
    go();
    chk("fl_pre_busy", int'(mul_busy), 1);
    chk("fl_pre_count", int'(count), 3);
    flush = 1;
    offer(14, 30, 31);
    go();
    flush = 0;
    in_valid = 0;
    chk("fl_count", int'(count), 0);
    chk("fl_busy", int'(mul_busy), 0);
    chk("fl_iv", int'(iv), 0);
    go();
    chk("fl_nocap", int'(count), 0);
    go(3);

    // Reset during issue.
    fx_ready = 0;
    offer(14, 12, 13); go();
    offer(14, 14, 15); go();
    in_valid = 0;
    fx_ready = 1;
    go();
    chk("rs_pre_iv", int'(iv), 1);
    reset = 1;
    flush = 1;
    offer(14, 2, 2);
    go();
    reset = 0;
    flush = 0;
    in_valid = 0;
    chk("rs_count", int'(count), 0);
    chk("rs_iv", int'(iv), 0);
    chk("rs_op", int'(i_op), 0);
    chk("rs_dst", int'(i_dst), 0);
    chk("rs_src", int'(i_src), 0);
    chk("rs_ready", int'(in_ready), 1);
    chk("rs_busy", int'(mul_busy), 0);
    go(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
